// File: rtl/final_pkg.sv
// Shared definitions for the multi-divisor search block: FSM state encoding
// and default widths for divisor words, memory addresses and candidates.
package final_pkg;

  localparam int unsigned D_WIDTH_DEF = 8;
  localparam int unsigned A_WIDTH_DEF = 8;
  localparam int unsigned V_WIDTH_DEF = 20;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_REQ  = 3'd1,
    LD_WAIT = 3'd2,
    CHK     = 3'd3,
    TEST    = 3'd4,
    DECIDE  = 3'd5,
    FIN     = 3'd6
  } state_t;

endpackage

// File: rtl/mds_hit_test.sv
// Combinational divisibility test of one candidate against one divisor.
// Ports:
//   Val - candidate value (V_WIDTH)
//   Div - divisor word (D_WIDTH)
//   Hit - 1 when Div is non-zero and divides Val exactly
module mds_hit_test
  import final_pkg::*;
#(
  parameter int unsigned V_WIDTH = V_WIDTH_DEF,
  parameter int unsigned D_WIDTH = D_WIDTH_DEF
) (
  input  logic [V_WIDTH-1:0] Val,
  input  logic [D_WIDTH-1:0] Div,
  output logic               Hit
);

  logic [V_WIDTH-1:0] div_safe;
  logic [V_WIDTH-1:0] rem;

  // A zero divisor is replaced by 1 so the divider never sees zero; the
  // result is then masked because zero is never a hit.
  always_comb begin
    div_safe = (Div == '0) ? V_WIDTH'(1) : V_WIDTH'(Div);
    rem      = Val % div_safe;
    Hit      = (Div != '0) && (rem == '0);
  end

endmodule

// File: rtl/multi_div_search.sv
// Multi-divisor search engine. On Go, reads NUM_DIV divisors from a
// synchronous-read memory into a local bank, then scans candidates
// Start..Limit and reports the first one divisible by at least MinHits
// of the loaded divisors.
// Ports:
//   Clk, Rst            - clock, asynchronous active-low reset
//   Go                  - start request (sampled in IDLE only)
//   Base/Start/Limit/MinHits - search arguments, latched on Go
//   Addr/Rw/En/Data     - memory master read port (Rw is always 0)
//   Busy/Done           - activity flag and one-cycle completion pulse
//   Found/Result/Hits   - search outcome, held until next Go is accepted
module multi_div_search
  import final_pkg::*;
#(
  parameter int unsigned D_WIDTH = D_WIDTH_DEF,
  parameter int unsigned A_WIDTH = A_WIDTH_DEF,
  parameter int unsigned V_WIDTH = V_WIDTH_DEF,
  parameter int unsigned NUM_DIV = 4,
  parameter int unsigned MEM_LAT = 1,
  localparam int unsigned H_WIDTH = $clog2(NUM_DIV + 1)
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Go,
  input  logic [A_WIDTH-1:0] Base,
  input  logic [V_WIDTH-1:0] Start,
  input  logic [V_WIDTH-1:0] Limit,
  input  logic [H_WIDTH-1:0] MinHits,
  output logic [A_WIDTH-1:0] Addr,
  output logic               Rw,
  output logic               En,
  input  logic [D_WIDTH-1:0] Data,
  output logic               Busy,
  output logic               Done,
  output logic               Found,
  output logic [V_WIDTH-1:0] Result,
  output logic [H_WIDTH-1:0] Hits
);

  localparam int unsigned I_WIDTH = (NUM_DIV > 1) ? $clog2(NUM_DIV) : 1;
  localparam int unsigned L_WIDTH = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned C_WIDTH = H_WIDTH + 1;
  localparam logic [I_WIDTH-1:0] LAST_I    = I_WIDTH'(NUM_DIV - 1);
  localparam logic [L_WIDTH-1:0] LAST_W    = L_WIDTH'(MEM_LAT - 1);
  localparam logic [H_WIDTH-1:0] NUM_DIV_H = H_WIDTH'(NUM_DIV);

  state_t state_q, state_d;

  logic [A_WIDTH-1:0] base_q, base_d;
  logic [V_WIDTH-1:0] start_q, start_d;
  logic [V_WIDTH-1:0] limit_q, limit_d;
  logic [H_WIDTH-1:0] minhits_q, minhits_d;
  logic [I_WIDTH-1:0] i_q, i_d;
  logic [L_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [D_WIDTH-1:0] bank_q [NUM_DIV];
  logic [D_WIDTH-1:0] bank_d [NUM_DIV];
  logic [V_WIDTH-1:0] val_q, val_d;
  logic [I_WIDTH-1:0] j_q, j_d;
  logic [H_WIDTH-1:0] cnt_q, cnt_d;

  logic [A_WIDTH-1:0] addr_q, addr_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               found_q, found_d;
  logic [V_WIDTH-1:0] result_q, result_d;
  logic [H_WIDTH-1:0] hits_q, hits_d;

  logic               hit_c;
  logic [C_WIDTH-1:0] cnt_hit_c;
  logic [C_WIDTH-1:0] rem_div_c;
  logic [C_WIDTH-1:0] min_c;
  logic [H_WIDTH-1:0] cnt_sat_c;
  logic               test_exit_c;
  logic               range_bad_c;

  // Divisibility of the current candidate by the current divisor
  mds_hit_test #(
    .V_WIDTH (V_WIDTH),
    .D_WIDTH (D_WIDTH)
  ) u_hit (
    .Val (val_q),
    .Div (bank_q[j_q]),
    .Hit (hit_c)
  );

  // Hit accounting and early-exit decision for the TEST state
  always_comb begin
    cnt_hit_c   = C_WIDTH'(cnt_q) + C_WIDTH'(hit_c);
    rem_div_c   = C_WIDTH'(LAST_I - j_q);
    min_c       = C_WIDTH'(minhits_q);
    cnt_sat_c   = (cnt_hit_c > C_WIDTH'(NUM_DIV)) ? NUM_DIV_H : H_WIDTH'(cnt_hit_c);
    // Exit once the target is met, divisors run out, or it is unreachable
    test_exit_c = (cnt_hit_c >= min_c) || (j_q == LAST_I) ||
                  ((cnt_hit_c + rem_div_c) < min_c);
    range_bad_c = (start_q > limit_q) || (minhits_q > NUM_DIV_H);
  end

  // State register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Go) state_d = LD_REQ;
      LD_REQ:  state_d = LD_WAIT;
      LD_WAIT: begin
        if (wcnt_q == LAST_W) begin
          state_d = (i_q == LAST_I) ? CHK : LD_REQ;
        end
      end
      CHK:     state_d = (range_bad_c || (minhits_q == '0)) ? FIN : TEST;
      TEST:    if (test_exit_c) state_d = DECIDE;
      DECIDE:  state_d = ((cnt_q >= minhits_q) || (val_q == limit_q)) ? FIN : TEST;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    base_d    = base_q;
    start_d   = start_q;
    limit_d   = limit_q;
    minhits_d = minhits_q;
    i_d       = i_q;
    wcnt_d    = wcnt_q;
    bank_d    = bank_q;
    val_d     = val_q;
    j_d       = j_q;
    cnt_d     = cnt_q;
    found_d   = found_q;
    result_d  = result_q;
    hits_d    = hits_q;

    case (state_q)
      IDLE: begin
        if (Go) begin
          base_d    = Base;
          start_d   = (Start == '0) ? V_WIDTH'(1) : Start;
          limit_d   = Limit;
          minhits_d = MinHits;
          i_d       = '0;
          found_d   = 1'b0;
          result_d  = '0;
          hits_d    = '0;
        end
      end
      LD_REQ: wcnt_d = '0;
      LD_WAIT: begin
        // Data is valid MEM_LAT cycles after the En cycle
        if (wcnt_q == LAST_W) begin
          bank_d[i_q] = Data;
          if (i_q != LAST_I) i_d = i_q + I_WIDTH'(1);
        end else begin
          wcnt_d = wcnt_q + L_WIDTH'(1);
        end
      end
      CHK: begin
        val_d = start_q;
        j_d   = '0;
        cnt_d = '0;
        if (range_bad_c) begin
          found_d  = 1'b0;
          result_d = '0;
          hits_d   = '0;
        end else if (minhits_q == '0) begin
          found_d  = 1'b1;
          result_d = start_q;
          hits_d   = '0;
        end
      end
      TEST: begin
        cnt_d = cnt_sat_c;
        if (j_q != LAST_I) j_d = j_q + I_WIDTH'(1);
      end
      DECIDE: begin
        if (cnt_q >= minhits_q) begin
          found_d  = 1'b1;
          result_d = val_q;
          hits_d   = cnt_q;
        end else if (val_q == limit_q) begin
          // Stop at Limit without incrementing, so no wrap past all ones
          found_d  = 1'b0;
          result_d = '0;
          hits_d   = '0;
        end else begin
          val_d = val_q + V_WIDTH'(1);
          j_d   = '0;
          cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Output next values, derived from the state being entered
  always_comb begin
    en_d   = (state_d == LD_REQ);
    addr_d = en_d ? (base_d + A_WIDTH'(i_d)) : '0;
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  // Datapath and output registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      base_q    <= '0;
      start_q   <= '0;
      limit_q   <= '0;
      minhits_q <= '0;
      i_q       <= '0;
      wcnt_q    <= '0;
      bank_q    <= '{default: '0};
      val_q     <= '0;
      j_q       <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
      result_q  <= '0;
      hits_q    <= '0;
    end else begin
      base_q    <= base_d;
      start_q   <= start_d;
      limit_q   <= limit_d;
      minhits_q <= minhits_d;
      i_q       <= i_d;
      wcnt_q    <= wcnt_d;
      bank_q    <= bank_d;
      val_q     <= val_d;
      j_q       <= j_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      found_q   <= found_d;
      result_q  <= result_d;
      hits_q    <= hits_d;
    end
  end

  assign Addr   = addr_q;
  assign Rw     = 1'b0;
  assign En     = en_q;
  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Found  = found_q;
  assign Result = result_q;
  assign Hits   = hits_q;

endmodule

// File: tb/tb_multi_div_search.sv
// Directed bench for multi_div_search: two instances (read latency 1 and 3)
// share stimulus, each with its own memory read pipeline.
module tb_multi_div_search;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned VW = 20;
  localparam int unsigned HW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          go;
  logic [AW-1:0] base;
  logic [VW-1:0] start;
  logic [VW-1:0] limit;
  logic [HW-1:0] minhits;

  logic [AW-1:0] addr1, addr3;
  logic          rw1, rw3, en1, en3;
  logic [DW-1:0] data1, data3;
  logic          busy1, busy3, done1, done3, found1, found3;
  logic [VW-1:0] result1, result3;
  logic [HW-1:0] hits1, hits3;

  logic [7:0] mem [256];
  logic [7:0] s0, s1;

  int unsigned done_cnt1 = 0, done_cnt3 = 0;
  int unsigned en_cnt1 = 0, en_cnt3 = 0;
  logic [7:0]  addr_log1 [64];
  logic [7:0]  addr_log3 [64];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  multi_div_search #(.MEM_LAT(1)) dut (
    .Clk(clk), .Rst(rst_n), .Go(go), .Base(base), .Start(start),
    .Limit(limit), .MinHits(minhits), .Addr(addr1), .Rw(rw1), .En(en1),
    .Data(data1), .Busy(busy1), .Done(done1), .Found(found1),
    .Result(result1), .Hits(hits1)
  );

  multi_div_search #(.MEM_LAT(3)) dut3 (
    .Clk(clk), .Rst(rst_n), .Go(go), .Base(base), .Start(start),
    .Limit(limit), .MinHits(minhits), .Addr(addr3), .Rw(rw3), .En(en3),
    .Data(data3), .Busy(busy3), .Done(done3), .Found(found3),
    .Result(result3), .Hits(hits3)
  );

  // Memory models: garbage 8'hEE whenever no read is in flight
  always @(posedge clk) begin
    data1 <= en1 ? mem[addr1] : 8'hEE;
    s0    <= en3 ? mem[addr3] : 8'hEE;
    s1    <= s0;
    data3 <= s1;
  end

  // Pulse counters and read-address log
  always @(negedge clk) begin
    if (done1) done_cnt1 <= done_cnt1 + 1;
    if (done3) done_cnt3 <= done_cnt3 + 1;
    if (en1) begin
      addr_log1[en_cnt1[5:0]] <= addr1;
      en_cnt1 <= en_cnt1 + 1;
    end
    if (en3) begin
      addr_log3[en_cnt3[5:0]] <= addr3;
      en_cnt3 <= en_cnt3 + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".ctl1"}, 64'({addr1, rw1, en1, busy1, done1, found1, hits1}), 64'd0);
    chk({tag, ".res1"}, 64'(result1), 64'd0);
    chk({tag, ".ctl3"}, 64'({addr3, rw3, en3, busy3, done3, found3, hits3}), 64'd0);
    chk({tag, ".res3"}, 64'(result3), 64'd0);
  endtask

  task automatic setmem(input logic [7:0] b, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3);
    logic [7:0] a;
    a = b;           mem[a] = d0;
    a = a + 8'd1;    mem[a] = d1;
    a = a + 8'd1;    mem[a] = d2;
    a = a + 8'd1;    mem[a] = d3;
  endtask

  task automatic run(input string tag, input logic [7:0] b,
                     input logic [7:0] d0, input logic [7:0] d1,
                     input logic [7:0] d2, input logic [7:0] d3,
                     input logic [VW-1:0] st, input logic [VW-1:0] lim,
                     input logic [HW-1:0] mh, input logic ef,
                     input logic [VW-1:0] er, input logic [HW-1:0] eh,
                     input bit chk_addr, input bit pester);
    int unsigned dc1, dc3, ec1, ec3;
    logic [7:0] ea;
    setmem(b, d0, d1, d2, d3);
    dc1 = done_cnt1; dc3 = done_cnt3; ec1 = en_cnt1; ec3 = en_cnt3;
    @(negedge clk);
    base = b; start = st; limit = lim; minhits = mh; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    if (pester) begin
      // Go pulses with different arguments while busy must be ignored
      repeat (4) @(negedge clk);
      base = 8'h00; start = 20'd99; minhits = 3'd0; go = 1'b1;
      repeat (3) @(negedge clk);
      go = 1'b0;
    end
    for (int c = 0; c < 30000; c++) begin
      if (done_cnt1 != dc1 && done_cnt3 != dc3) break;
      @(negedge clk);
      #1;
    end
    repeat (3) @(negedge clk);
    #1;
    chk({tag, ".done1"}, 64'(done_cnt1 - dc1), 64'd1);
    chk({tag, ".done3"}, 64'(done_cnt3 - dc3), 64'd1);
    chk({tag, ".found1"}, 64'(found1), 64'(ef));
    chk({tag, ".result1"}, 64'(result1), 64'(er));
    chk({tag, ".hits1"}, 64'(hits1), 64'(eh));
    chk({tag, ".found3"}, 64'(found3), 64'(ef));
    chk({tag, ".result3"}, 64'(result3), 64'(er));
    chk({tag, ".hits3"}, 64'(hits3), 64'(eh));
    chk({tag, ".en1"}, 64'(en_cnt1 - ec1), 64'd4);
    chk({tag, ".en3"}, 64'(en_cnt3 - ec3), 64'd4);
    chk({tag, ".busy"}, 64'({busy1, busy3, rw1, rw3}), 64'd0);
    if (chk_addr) begin
      ea = b;
      for (int k = 0; k < 4; k++) begin
        chk({tag, ".addr1"}, 64'(addr_log1[6'(ec1 + 32'(k))]), 64'(ea));
        chk({tag, ".addr3"}, 64'(addr_log3[6'(ec3 + 32'(k))]), 64'(ea));
        ea = ea + 8'd1;
      end
    end
  endtask

  initial begin
    int unsigned rc1, rc3;
    rst_n = 1'b0; go = 1'b0; base = '0; start = '0; limit = '0; minhits = '0;
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run("t1_2357",   8'h10, 8'd2, 8'd3, 8'd5, 8'd7, 20'd1, 20'd970200, 3'd3,
        1'b1, 20'd30, 3'd3, 1'b1, 1'b0);
    run("t2_zero",   8'h20, 8'd0, 8'd4, 8'd6, 8'd0, 20'd1, 20'd1000, 3'd2,
        1'b1, 20'd12, 3'd2, 1'b0, 1'b0);
    run("t3_none",   8'h30, 8'd7, 8'd11, 8'd13, 8'd17, 20'd1, 20'd1000, 3'd4,
        1'b0, 20'd0, 3'd0, 1'b0, 1'b0);
    run("t4_max",    8'h40, 8'd3, 8'd5, 8'd11, 8'd31, 20'hFFFFF, 20'hFFFFF, 3'd4,
        1'b1, 20'hFFFFF, 3'd4, 1'b0, 1'b0);
    run("t5_nowrap", 8'h50, 8'd2, 8'd4, 8'd8, 8'd16, 20'hFFFFF, 20'hFFFFF, 3'd1,
        1'b0, 20'd0, 3'd0, 1'b0, 1'b0);
    run("t6_awrap",  8'hFE, 8'd2, 8'd3, 8'd5, 8'd7, 20'd1, 20'd100, 3'd3,
        1'b1, 20'd30, 3'd3, 1'b1, 1'b0);
    run("t7_mh0",    8'h60, 8'd2, 8'd3, 8'd5, 8'd7, 20'd77, 20'd100, 3'd0,
        1'b1, 20'd77, 3'd0, 1'b0, 1'b0);
    run("t8_mh5",    8'h70, 8'd2, 8'd3, 8'd5, 8'd7, 20'd1, 20'd100, 3'd5,
        1'b0, 20'd0, 3'd0, 1'b0, 1'b0);
    run("t9_start0", 8'h80, 8'd0, 8'd0, 8'd0, 8'd5, 20'd0, 20'd100, 3'd1,
        1'b1, 20'd5, 3'd1, 1'b0, 1'b0);
    run("t10_range", 8'h90, 8'd2, 8'd3, 8'd5, 8'd7, 20'd50, 20'd10, 3'd1,
        1'b0, 20'd0, 3'd0, 1'b0, 1'b0);
    run("t11_pester", 8'hA0, 8'd7, 8'd11, 8'd13, 8'd17, 20'd1, 20'd1000, 3'd4,
        1'b0, 20'd0, 3'd0, 1'b0, 1'b1);

    // Reset in the middle of a long search: immediate clear, no Done
    setmem(8'hB0, 8'd7, 8'd11, 8'd13, 8'd17);
    rc1 = done_cnt1; rc3 = done_cnt3;
    @(negedge clk);
    base = 8'hB0; start = 20'd1; limit = 20'd1000; minhits = 3'd4; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    chk("rst_mid.busy", 64'({busy1, busy3}), 64'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle("rst_mid");
    repeat (5) @(negedge clk);
    #1;
    chk("rst_mid.nodone1", 64'(done_cnt1 - rc1), 64'd0);
    chk("rst_mid.nodone3", 64'(done_cnt3 - rc3), 64'd0);
    chk_idle("rst_hold");
    rst_n = 1'b1;

    run("t12_after", 8'hC0, 8'd0, 8'd0, 8'd3, 8'd0, 20'd1, 20'd10, 3'd1,
        1'b1, 20'd3, 3'd1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
